// File: rtl/bf_io_pkg.sv
// Shared constants and FSM encoding for the brainfuck core's I/O responders.
package bf_io_pkg;

    localparam int KEY_W  = 8;
    localparam int DATA_W = 16;

    // Leading bit of an LCD command word: 1 = data write (character), 0 = control.
    localparam logic LCD_DATA_PREFIX = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rd_state_t;

    function automatic logic [DATA_W-1:0] key_to_word(input logic [KEY_W-1:0] key);
        return {{(DATA_W-KEY_W){1'b0}}, key};
    endfunction

endpackage

// File: rtl/bf_key_fifo.sv
// Key-code FIFO; a push into a full FIFO succeeds only when a pop frees a slot on the same edge.
module bf_key_fifo
    import bf_io_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_rst,
    input  logic             push,
    input  logic [KEY_W-1:0] push_data,
    input  logic             pop,
    output logic [KEY_W-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [KEY_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (s_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bf_key_reader.sv
// Keyboard responder for the core's data-read port (r_sel=1); stalls the core until a key exists.
// Optional macro BF_KEY_ECHO_EN adds echo_en/echo_data, an LCD data-write echo of each key read.
module bf_key_reader
    import bf_io_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    input  logic              r_req,
    input  logic              r_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              data_den,
    output logic [AW:0]       key_count,
    output logic              key_full,
    output logic              overflow,
    output logic [1:0]        dbg_state
`ifdef BF_KEY_ECHO_EN
    ,
    output logic              echo_en,
    output logic [KEY_W:0]    echo_data
`endif
);

    // Handshake: a request is accepted only in IDLE with r_req&r_sel; it completes with a
    // single data_den cycle. Requests seen in WAIT or RESP are dropped, never queued.

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic              w_pop;
    logic [KEY_W-1:0]  w_pop_data;
    logic              w_empty;
    logic [DATA_W-1:0] r_data_out;
    logic              r_overflow;

    bf_key_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .s_rst    (s_rst),
        .push     (key_valid),
        .push_data(key_in),
        .pop      (w_pop),
        .pop_data (w_pop_data),
        .count    (key_count),
        .full     (key_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_state <= IDLE;
        else if (s_rst) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_req && r_sel) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = RESP;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_overflow <= 1'b0;
        end else if (s_rst) begin
            r_data_out <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) r_data_out <= key_to_word(w_pop_data);
            // A full FIFO still accepts a key when the same edge pops one.
            if (key_valid && key_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign data_out  = r_data_out;
    assign data_den  = (r_state == RESP);
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

`ifdef BF_KEY_ECHO_EN
    logic [KEY_W:0] r_echo_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_echo_data <= '0;
        else if (s_rst) r_echo_data <= '0;
        else if (w_pop) r_echo_data <= {LCD_DATA_PREFIX, w_pop_data};
    end

    assign echo_en   = data_den;
    assign echo_data = r_echo_data;
`endif

endmodule

// File: tb/tb_bf_key_reader.sv
// Self-checking bench for bf_key_reader: a FIFO scoreboard of expected read words.
module tb_bf_key_reader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk;
    logic        rst;
    logic        s_rst;
    logic [7:0]  key_in;
    logic        key_valid;
    logic        r_req;
    logic        r_sel;
    logic [15:0] data_out;
    logic        data_den;
    logic [AW:0] key_count;
    logic        key_full;
    logic        overflow;
    logic [1:0]  dbg_state;
`ifdef BF_KEY_ECHO_EN
    logic        echo_en;
    logic [8:0]  echo_data;
`endif

    int checks;
    int errors;
    logic [15:0] exp_q[$];
    logic        model_ovf;

    bf_key_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_rst    (s_rst),
        .key_in   (key_in),
        .key_valid(key_valid),
        .r_req    (r_req),
        .r_sel    (r_sel),
        .data_out (data_out),
        .data_den (data_den),
        .key_count(key_count),
        .key_full (key_full),
        .overflow (overflow),
        .dbg_state(dbg_state)
`ifdef BF_KEY_ECHO_EN
        ,
        .echo_en  (echo_en),
        .echo_data(echo_data)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_rst = 1'b0; key_in = '0; key_valid = 1'b0; r_req = 1'b0; r_sel = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    // Driver tasks
    task automatic strobe_key(input logic [7:0] k);
        key_in = k;
        key_valid = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back({8'h00, k});
        else model_ovf = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic issue_req();
        r_req = 1'b1;
        r_sel = 1'b1;
        tick();
        r_req = 1'b0;
        r_sel = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        checks++; if (key_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", key_count); end
        checks++; if (key_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", key_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL reset_den: got %b expected 0", data_den); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data_out); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
`ifdef BF_KEY_ECHO_EN
        checks++; if (echo_en !== 1'b0 || echo_data !== 9'h000) begin errors++; $display("FAIL reset_echo: got %b/%h expected 0/000", echo_en, echo_data); end
`endif
    endtask

    task automatic test_basic_read();
        logic [15:0] exp;
        int          exp_cnt;
        do_reset();
        strobe_key(8'h41);
        strobe_key(8'h42);
        checks++; if (key_count !== 5'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", key_count); end
        for (int n = 0; n < 2; n++) begin
            exp_cnt = exp_q.size() - 1;
            issue_req();
            exp = exp_q.pop_front();
            checks++; if (data_den !== 1'b1) begin errors++; $display("FAIL basic_den_latency: got %b expected 1", data_den); end
            checks++; if (data_out !== exp) begin errors++; $display("FAIL basic_data: got %h expected %h", data_out, exp); end
            checks++; if (key_count !== (AW+1)'(exp_cnt)) begin errors++; $display("FAIL basic_count_dec: got %0d expected %0d", key_count, exp_cnt); end
            tick();
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL basic_den_pulse: got %b expected 0", data_den); end
            checks++; if (data_out !== exp) begin errors++; $display("FAIL basic_data_hold: got %h expected %h", data_out, exp); end
        end
    endtask

    task automatic test_wait_stall();
        logic [15:0] exp;
        int          lat;
        do_reset();
        issue_req();
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL wait_state: got %0d expected 1", dbg_state); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL wait_early_den: got %b expected 0", data_den); end
            tick();
        end
        strobe_key(8'h33);
        lat = -1;
        for (int i = 0; i < 6; i++) begin
            if (data_den === 1'b1) begin lat = i + 1; break; end
            tick();
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL wait_latency: got %0d expected 2", lat); end
        exp = exp_q.pop_front();
        checks++; if (data_out !== exp) begin errors++; $display("FAIL wait_data: got %h expected %h", data_out, exp); end
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        do_reset();
        for (int i = 0; i < 17; i++) strobe_key(8'(i));
        checks++; if (key_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", key_full); end
        checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL ovf_flag: got %b expected %b", overflow, model_ovf); end
        checks++; if (key_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", key_count); end
        for (int i = 0; i < 16; i++) begin
            issue_req();
            exp = exp_q.pop_front();
            checks++; if (data_den !== 1'b1 || data_out !== exp) begin errors++; $display("FAIL ovf_drain_%0d: got %b/%h expected 1/%h", i, data_den, data_out, exp); end
            tick();
        end
        checks++; if (key_count !== 5'd0) begin errors++; $display("FAIL ovf_lost_key: got %0d expected 0", key_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        model_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_srst_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) strobe_key(8'h80 + 8'(i));
        checks++; if (key_full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", key_full); end
        r_req = 1'b1; r_sel = 1'b1; key_valid = 1'b1; key_in = 8'hAA;
        exp = exp_q.pop_front();
        exp_q.push_back(16'h00AA);
        tick();
        r_req = 1'b0; r_sel = 1'b0; key_valid = 1'b0;
        checks++; if (data_den !== 1'b1 || data_out !== exp) begin errors++; $display("FAIL fpp_data: got %b/%h expected 1/%h", data_den, data_out, exp); end
        checks++; if (key_count !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d expected 16", key_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", overflow); end
        tick();
        for (int i = 0; i < 16; i++) begin
            issue_req();
            exp = exp_q.pop_front();
            checks++; if (data_den !== 1'b1 || data_out !== exp) begin errors++; $display("FAIL fpp_drain_%0d: got %b/%h expected 1/%h", i, data_den, data_out, exp); end
            tick();
        end
    endtask

    task automatic test_sel_low();
        logic [15:0] exp;
        do_reset();
        strobe_key(8'h55);
        r_req = 1'b1; r_sel = 1'b0;
        tick();
        r_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL sel_low_den: got %b expected 0", data_den); end
            tick();
        end
        checks++; if (key_count !== 5'd1) begin errors++; $display("FAIL sel_low_count: got %0d expected 1", key_count); end
        issue_req();
        exp = exp_q.pop_front();
        checks++; if (data_den !== 1'b1 || data_out !== exp) begin errors++; $display("FAIL sel_low_read: got %b/%h expected 1/%h", data_den, data_out, exp); end
        tick();
    endtask

    task automatic test_sync_clear();
        do_reset();
        for (int i = 0; i < 3; i++) strobe_key(8'(8'h20 + $urandom_range(0, 15)));
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        exp_q.delete();
        checks++; if (key_count !== 5'd0) begin errors++; $display("FAIL srst_count: got %0d expected 0", key_count); end
        issue_req();
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL srst_wait_entry: got %0d expected 1", dbg_state); end
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL srst_state: got %0d expected 0", dbg_state); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL srst_ovf: got %b expected 0", overflow); end
        strobe_key(8'h77);
        for (int i = 0; i < 4; i++) begin
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL srst_stale_req: got %b expected 0", data_den); end
            tick();
        end
        checks++; if (key_count !== 5'd1) begin errors++; $display("FAIL srst_key_kept: got %0d expected 1", key_count); end
    endtask

`ifdef BF_KEY_ECHO_EN
    task automatic test_echo();
        do_reset();
        strobe_key(8'h48);
        issue_req();
        checks++; if (echo_en !== 1'b1) begin errors++; $display("FAIL echo_en: got %b expected 1", echo_en); end
        checks++; if (echo_data !== 9'h148) begin errors++; $display("FAIL echo_data: got %h expected 148", echo_data); end
        tick();
        checks++; if (echo_en !== 1'b0) begin errors++; $display("FAIL echo_pulse: got %b expected 0", echo_en); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        model_ovf = 1'b0;
        test_reset();
        test_basic_read();
        test_wait_stall();
        test_overflow();
        test_full_push_pop();
        test_sel_low();
        test_sync_clear();
`ifdef BF_KEY_ECHO_EN
        test_echo();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
